// File: rtl/udp_not_pipe.sv
// udp_not_pipe: CHANNELS single-bit UDP-style inverters/toggles behind a DEPTH-stage valid/ready pipeline.
// Optional x-propagation is enabled with `define UDP_NOT_PIPE_XPROP_EN (default: 2-state, x/z read as 0).
module udp_not_pipe #(
    parameter int CHANNELS = 4,
    parameter int IN_W     = 3,
    parameter int DEPTH    = 2,
    parameter int MODE     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*IN_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [CHANNELS-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Handshake: a beat transfers on a posedge where valid & ready are both high;
    // ready never depends on valid of the same interface, and ready is forced low during rst.

    logic [CHANNELS-1:0] bit_in;
    logic [CHANNELS-1:0] bit_eff;
    logic [CHANNELS-1:0] beat_val;
    logic [CHANNELS-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]    stage_v;
    logic [DEPTH-1:0]    ready;
    logic                accept;
    logic                unused_upper;

    // Only bit 0 of each slice carries the channel value; the rest is deliberately dropped.
    assign unused_upper = ^in_data;

    always_comb begin
        bit_in = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bit_in[c] = in_data[c*IN_W];
        end
    end

`ifdef UDP_NOT_PIPE_XPROP_EN
    assign bit_eff = bit_in;
`else
    always_comb begin
        bit_eff = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bit_eff[c] = (bit_in[c] === 1'b1);
        end
    end
`endif

    generate
        if (MODE == 0) begin : g_invert
            assign beat_val = ~bit_eff;
        end else begin : g_toggle
            logic [CHANNELS-1:0] tog_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    tog_q <= '0;
                end else if (accept) begin
                    tog_q <= tog_q ^ bit_eff;
                end
            end
            // The value entering stage 0 is the post-update state.
            assign beat_val = tog_q ^ bit_eff;
        end
    endgenerate

    // ready[k] = ~v[k] | ready[k+1] unrolled: a stage can take data unless it and every
    // stage after it is full while the sink is stalled.
    always_comb begin
        logic full;
        ready = '0;
        for (int k = 0; k < DEPTH; k++) begin
            full = 1'b1;
            for (int j = k; j < DEPTH; j++) begin
                full = full & stage_v[j];
            end
            ready[k] = ~full | out_ready;
        end
    end

    assign in_ready = ready[0] & ~rst;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_v[k] <= 1'b0;
                stage_d[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                stage_v[0] <= accept;
                if (accept) begin
                    stage_d[0] <= beat_val;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (ready[k]) begin
                    stage_v[k] <= stage_v[k-1];
                    if (stage_v[k-1]) begin
                        stage_d[k] <= stage_d[k-1];
                    end
                end
            end
        end
    end

    assign out_data  = stage_d[DEPTH-1];
    assign out_valid = stage_v[DEPTH-1];

endmodule
